// File: rtl/ppi_bus_master_pkg.sv
// Shared definitions for the PPI bus master: FSM state encoding,
// PPI register-select constants, phase counter width and the helper that
// turns a phase-length parameter into a counter load value.
package ppi_bus_master_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] PORT_A = 2'd0;
  localparam logic [1:0] PORT_B = 2'd1;
  localparam logic [1:0] PORT_C = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  // Phase length in cycles -> down-counter load value (length-1).
  // A length of 0 is treated as 1; lengths above 15 saturate at 15.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned p);
    if (p == 0)       return '0;
    else if (p > 15)  return CNT_W'(14);
    else              return CNT_W'(p - 1);
  endfunction

endpackage

// File: rtl/ppi_bus_tristate.sv
// 8-bit tri-state driver for the PPI data bus.
// Ports:
//   data_i - value to drive
//   oe_i   - 1 = drive data_i onto bus_io, 0 = high-Z
//   bus_io - shared bidirectional data bus
module ppi_bus_tristate (
  input  logic [7:0] data_i,
  input  logic       oe_i,
  inout  wire  [7:0] bus_io
);

  assign bus_io = oe_i ? data_i : 'z;

endmodule

// File: rtl/ppi_bus_master.sv
// Host-side bus master generating 8255-style PPI read/write cycles.
// A transaction runs SETUP -> STROBE -> HOLD -> RECOVER, each phase timed
// by one shared down-counter, then returns to IDLE with a one-cycle Done.
// Ports:
//   Clk, ResetN          - clock, asynchronous active-low reset
//   Req, ReqWrite        - host request, 1 = write / 0 = read
//   ReqAddr, ReqData     - register select and write data
//   Busy, Done           - transaction in progress, completion pulse
//   RdData               - last read result
//   CsN, RdN, WrN, Addr  - PPI control and address
//   DataBus              - PPI data bus, driven only during a write
module ppi_bus_master #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       Req,
  input  logic       ReqWrite,
  input  logic [1:0] ReqAddr,
  input  logic [7:0] ReqData,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] RdData,
  output logic       CsN,
  output logic       RdN,
  output logic       WrN,
  output logic [1:0] Addr,
  inout  wire  [7:0] DataBus
);

  import ppi_bus_master_pkg::*;

  localparam logic [CNT_W-1:0] LD_SETUP   = cyc_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_STROBE  = cyc_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] LD_HOLD    = cyc_load(HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_RECOVER = cyc_load(RECOVER_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rd_q, rd_d;
  logic             done_q, done_d;

  logic             active;
  logic             bus_oe;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Req) begin
          state_d = ST_SETUP;
          cnt_d   = LD_SETUP;
          wr_d    = ReqWrite;
          addr_d  = ReqAddr;
          data_d  = ReqData;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_STROBE;
          cnt_d   = LD_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
          // Sample at the edge that ends the strobe, while RdN is still low.
          if (!wr_q) rd_d = DataBus;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_RECOVER;
          cnt_d   = LD_RECOVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  // Bus outputs decode directly from the state register so an asynchronous
  // reset releases strobes and chip select in the same instant.
  assign active = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                  (state_q == ST_HOLD);
  assign bus_oe = active && wr_q;

  assign CsN    = !active;
  assign Addr   = active ? addr_q : '0;
  assign RdN    = !((state_q == ST_STROBE) && !wr_q);
  assign WrN    = !((state_q == ST_STROBE) &&  wr_q);
  assign Busy   = (state_q != ST_IDLE);
  assign Done   = done_q;
  assign RdData = rd_q;

  ppi_bus_tristate u_tristate (
    .data_i (data_q),
    .oe_i   (bus_oe),
    .bus_io (DataBus)
  );

endmodule

// File: tb/tb_ppi_bus_master.sv
module tb_ppi_bus_master;

  logic       Clk;
  logic       ResetN;
  logic       Req, ReqWrite;
  logic [1:0] ReqAddr;
  logic [7:0] ReqData;
  logic       Busy, Done, CsN, RdN, WrN;
  logic [7:0] RdData;
  logic [1:0] Addr;
  wire  [7:0] DataBus;
  logic [7:0] mdl_rd;

  logic       Req2, ReqWrite2;
  logic [1:0] ReqAddr2;
  logic [7:0] ReqData2;
  logic       Busy2, Done2, CsN2, RdN2, WrN2;
  logic [7:0] RdData2;
  logic [1:0] Addr2;
  wire  [7:0] DataBus2;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // PPI model: drives the bus only while the read strobe is low.
  assign DataBus = !RdN ? mdl_rd : 8'hzz;

  ppi_bus_master dut (
    .Clk(Clk), .ResetN(ResetN), .Req(Req), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .Busy(Busy), .Done(Done),
    .RdData(RdData), .CsN(CsN), .RdN(RdN), .WrN(WrN), .Addr(Addr),
    .DataBus(DataBus)
  );

  ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2), .RECOVER_CYC(2)) dut2 (
    .Clk(Clk), .ResetN(ResetN), .Req(Req2), .ReqWrite(ReqWrite2),
    .ReqAddr(ReqAddr2), .ReqData(ReqData2), .Busy(Busy2), .Done(Done2),
    .RdData(RdData2), .CsN(CsN2), .RdN(RdN2), .WrN(WrN2), .Addr(Addr2),
    .DataBus(DataBus2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single transaction on dut with default timing. Caller is at a negedge.
  // Cycle k=1 is SETUP, 2-3 STROBE, 4 HOLD, 5 RECOVER, 6 Done.
  // rexp is the RdData expected in the Done cycle.
  task automatic txn1(input string nm, input logic wr, input logic [1:0] a,
                      input logic [7:0] d, input logic [7:0] rexp, input bit tog);
    bit act, stb;
    Req = 1'b1; ReqWrite = wr; ReqAddr = a; ReqData = d;
    @(posedge Clk); #1;
    Req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      act = (k <= 4);
      stb = (k == 2) || (k == 3);
      check($sformatf("%s.CsN[%0d]", nm, k), CsN, !act);
      check($sformatf("%s.WrN[%0d]", nm, k), WrN, !(stb && wr));
      check($sformatf("%s.RdN[%0d]", nm, k), RdN, !(stb && !wr));
      check($sformatf("%s.Addr[%0d]", nm, k), Addr, act ? a : 2'd0);
      check($sformatf("%s.oe[%0d]", nm, k), dut.bus_oe, act && wr);
      if (act && wr) check($sformatf("%s.Data[%0d]", nm, k), DataBus, d);
      check($sformatf("%s.Busy[%0d]", nm, k), Busy, k <= 5);
      check($sformatf("%s.Done[%0d]", nm, k), Done, k == 6);
      if (k == 6) check($sformatf("%s.RdData", nm), RdData, rexp);
      if (tog && k <= 4) begin
        Req = 1'(k & 1); ReqWrite = ~wr; ReqAddr = ~a; ReqData = ~d;
      end else begin
        Req = 1'b0;
      end
    end
  endtask

  initial begin
    int done_at, wr_low, cs_low;
    bit f, s;
    ResetN = 1'b0; Req = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqData = '0;
    Req2 = 1'b0; ReqWrite2 = 1'b0; ReqAddr2 = '0; ReqData2 = '0;
    mdl_rd = 8'h05;

    // Reset values before any clock edge.
    #3;
    check("rst.CsN", CsN, 1'b1);
    check("rst.RdN", RdN, 1'b1);
    check("rst.WrN", WrN, 1'b1);
    check("rst.Addr", Addr, 2'd0);
    check("rst.Busy", Busy, 1'b0);
    check("rst.Done", Done, 1'b0);
    check("rst.RdData", RdData, 8'h00);
    check("rst.oe", dut.bus_oe, 1'b0);

    @(negedge Clk);
    ResetN = 1'b1;
    // Control-word write, then read port B, then write with toggling inputs.
    txn1("wr80", 1'b1, 2'd3, 8'h80, 8'h00, 1'b0);
    txn1("rdB", 1'b0, 2'd1, 8'hFF, 8'h05, 1'b0);
    txn1("tog", 1'b1, 2'd2, 8'hA6, 8'h05, 1'b1);

    // Back-to-back with Req held high; second request changes address/data.
    Req = 1'b1; ReqWrite = 1'b1; ReqAddr = 2'd0; ReqData = 8'h11;
    @(posedge Clk); #1;
    ReqAddr = 2'd1; ReqData = 8'h22;
    for (int k = 1; k <= 13; k++) begin
      @(negedge Clk);
      f = (k <= 4);
      s = (k >= 7) && (k <= 10);
      check($sformatf("b2b.CsN[%0d]", k), CsN, !(f || s));
      check($sformatf("b2b.WrN[%0d]", k), WrN, !(k == 2 || k == 3 || k == 8 || k == 9));
      check($sformatf("b2b.Addr[%0d]", k), Addr, s ? 2'd1 : 2'd0);
      if (f) check($sformatf("b2b.Data[%0d]", k), DataBus, 8'h11);
      if (s) check($sformatf("b2b.Data[%0d]", k), DataBus, 8'h22);
      check($sformatf("b2b.Done[%0d]", k), Done, k == 6 || k == 12);
      check($sformatf("b2b.Busy[%0d]", k), Busy, k <= 5 || (k >= 7 && k <= 11));
      if (k == 7) Req = 1'b0;
    end

    // Reset pulsed during the strobe of a write.
    Req = 1'b1; ReqWrite = 1'b1; ReqAddr = 2'd2; ReqData = 8'h5A;
    @(posedge Clk); #1;
    Req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("abort.WrN_pre", WrN, 1'b0);
    #2 ResetN = 1'b0;
    #1;
    check("abort.WrN", WrN, 1'b1);
    check("abort.CsN", CsN, 1'b1);
    check("abort.oe", dut.bus_oe, 1'b0);
    check("abort.Busy", Busy, 1'b0);
    check("abort.RdData", RdData, 8'h00);
    @(posedge Clk); @(posedge Clk); #1;
    check("abort.Done", Done, 1'b0);
    check("abort.CsN2", CsN, 1'b1);
    @(negedge Clk);
    ResetN = 1'b1;
    txn1("postrst", 1'b0, 2'd0, 8'h00, 8'h05, 1'b0);

    // Non-default timing: 3+4+2+2 = 11 cycles to Done.
    Req2 = 1'b1; ReqWrite2 = 1'b1; ReqAddr2 = 2'd2; ReqData2 = 8'h3C;
    @(posedge Clk); #1;
    Req2 = 1'b0;
    done_at = 0; wr_low = 0; cs_low = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (!WrN2) wr_low++;
      if (!CsN2) cs_low++;
      if (Done2 && done_at == 0) done_at = k;
      if (k == 5) begin
        check("p2.WrN5", WrN2, 1'b0);
        check("p2.Data5", DataBus2, 8'h3C);
      end
    end
    check("p2.done_at", done_at, 32'd12);
    check("p2.wr_low", wr_low, 32'd4);
    check("p2.cs_low", cs_low, 32'd9);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
